// File: rtl/fir_sample_feeder.sv
// -----------------------------------------------------------------------------
// fir_sample_feeder
//
// Upstream stage of the 16-tap FIR. Signed samples arrive on a valid/ready
// interface and are queued in a small FIFO. The feeder hands them to the FIR
// one at a time. Each sample gets a one-cycle fir_input_ready strobe, and
// fir_in is held stable until the FIR's completion pulse arrives. This hides
// the FIR's per-sample occupancy from the producer.
//
// An optional idle gap follows each completion. A watchdog bounds the wait
// for completion and raises a sticky error flag when it expires.
//
// Parameters
//   WIDTH    sample width in bits
//   DEPTH    FIFO depth in entries (power of 2, >= 2)
//   MIN_GAP  idle cycles after fir_output_ready before the next strobe
//   TIMEOUT  max cycles spent waiting for fir_output_ready
//
// Ports
//   clock             rising-edge clock
//   rst               asynchronous reset, active-high
//   in_data           signed sample from the producer
//   in_valid          producer has a sample
//   in_ready          feeder can accept (FIFO not full, from registered count)
//   fir_in            registered sample to the FIR
//   fir_input_ready   registered one-cycle strobe to the FIR
//   fir_output_ready  FIR completion pulse
//   fifo_level        current FIFO occupancy
//   busy              high whenever the FSM is not IDLE
//   clear_err         synchronous clear of timeout_err
//   timeout_err       sticky watchdog flag
// -----------------------------------------------------------------------------
module fir_sample_feeder #(
  parameter int WIDTH   = 16,
  parameter int DEPTH   = 8,
  parameter int MIN_GAP = 0,
  parameter int TIMEOUT = 64
) (
  input  logic                      clock,
  input  logic                      rst,
  input  logic signed [WIDTH-1:0]   in_data,
  input  logic                      in_valid,
  output logic                      in_ready,
  output logic signed [WIDTH-1:0]   fir_in,
  output logic                      fir_input_ready,
  input  logic                      fir_output_ready,
  output logic [$clog2(DEPTH):0]    fifo_level,
  output logic                      busy,
  input  logic                      clear_err,
  output logic                      timeout_err
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int GW = (MIN_GAP > 0) ? $clog2(MIN_GAP + 1) : 1;
  localparam int WW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    BUSY  = 2'd2,
    GAP   = 2'd3
  } state_t;

  state_t            state_q, state_d;

  logic [WIDTH-1:0]  mem [DEPTH];
  logic [AW-1:0]     wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]     count_q;
  logic [GW-1:0]     gap_q;
  logic [WW-1:0]     wd_q;

  logic              push, pop;
  logic              gap_load, gap_dec;
  logic              wd_clr, wd_inc;
  logic              err_set;

  // Full depends only on the registered count, so there is no path from
  // in_valid (or anything else) to in_ready.
  assign in_ready   = (count_q != CW'(DEPTH));
  assign push       = in_valid && in_ready;
  assign fifo_level = count_q;
  assign busy       = (state_q != IDLE);

  // ---------------------------------------------------------------------------
  // Next-state and control decode
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every signal gets a default before the case so that no path
    // leaves it unassigned, which would infer a latch.
    state_d  = state_q;
    pop      = 1'b0;
    gap_load = 1'b0;
    gap_dec  = 1'b0;
    wd_clr   = 1'b0;
    wd_inc   = 1'b0;
    err_set  = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (count_q != '0) begin
          pop     = 1'b1;
          state_d = ISSUE;
        end
      end

      ISSUE: begin
        wd_clr  = 1'b1;
        state_d = BUSY;
      end

      BUSY: begin
        if (fir_output_ready) begin
          if (MIN_GAP > 0) begin
            gap_load = 1'b1;
            state_d  = GAP;
          end else begin
            state_d  = IDLE;
          end
        end else if (wd_q == WW'(TIMEOUT - 1)) begin
          err_set = 1'b1;
          state_d = IDLE;
        end else begin
          wd_inc = 1'b1;
        end
      end

      GAP: begin
        // Completion pulses here are spurious and deliberately ignored.
        if (gap_q == GW'(1)) begin
          state_d = IDLE;
        end else begin
          gap_dec = 1'b1;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clock or posedge rst) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // ---------------------------------------------------------------------------
  // FIFO storage
  // ---------------------------------------------------------------------------
  // NOTE: the sample array has no reset; the pointers and count define which
  // entries are meaningful, and leaving it unreset lets it map onto plain RAM.
  always_ff @(posedge clock) begin
    if (push) begin
      mem[wr_ptr_q] <= in_data;
    end
  end

  // ---------------------------------------------------------------------------
  // FIFO pointers and occupancy. Pointers wrap naturally at DEPTH because
  // DEPTH is a power of two.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clock or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      unique case ({push, pop})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // FIR-facing outputs. fir_in only changes on the IDLE->ISSUE edge, so it
  // stays stable while the FIR samples it and while the FIR is computing.
  // The strobe is simply the registered pop, so it is high exactly in ISSUE.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clock or posedge rst) begin
    if (rst) begin
      fir_in          <= '0;
      fir_input_ready <= 1'b0;
    end else begin
      fir_input_ready <= pop;
      if (pop) begin
        fir_in <= mem[rd_ptr_q];
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Gap counter, watchdog and sticky error
  // ---------------------------------------------------------------------------
  always_ff @(posedge clock or posedge rst) begin
    if (rst) begin
      gap_q       <= '0;
      wd_q        <= '0;
      timeout_err <= 1'b0;
    end else begin
      if (gap_load) begin
        gap_q <= GW'(MIN_GAP);
      end else if (gap_dec) begin
        gap_q <= gap_q - GW'(1);
      end

      if (wd_clr) begin
        wd_q <= '0;
      end else if (wd_inc) begin
        wd_q <= wd_q + WW'(1);
      end

      // A timeout on the same edge as clear_err wins.
      if (err_set) begin
        timeout_err <= 1'b1;
      end else if (clear_err) begin
        timeout_err <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_fir_sample_feeder.sv
// -----------------------------------------------------------------------------
// tb_fir_sample_feeder
//
// Directed bench for fir_sample_feeder. The main instance uses MIN_GAP=0 and
// talks to a behavioural 16-tap FIR. The FIR shifts in fir_in on each strobe
// and pulses completion a programmable number of cycles later. The second
// instance uses MIN_GAP=3 and is driven by hand for the gap timing.
// Outputs are sampled 1 ns after the falling edge. "cyc" holds the index of
// the most recent rising edge.
// -----------------------------------------------------------------------------
module tb_fir_sample_feeder;

  logic clock = 1'b0;
  logic rst   = 1'b1;
  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  // Main instance (MIN_GAP = 0)
  logic [15:0] in_data;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] fir_in;
  logic        fir_input_ready;
  logic        fir_output_ready;
  logic [3:0]  fifo_level;
  logic        busy;
  logic        clear_err;
  logic        timeout_err;

  // Gap instance (MIN_GAP = 3)
  logic [15:0] g_in_data;
  logic        g_in_valid;
  logic        g_in_ready;
  logic [15:0] g_fir_in;
  logic        g_strobe;
  logic        g_ack;
  logic [3:0]  g_level;
  logic        g_busy;
  logic        g_clear_err;
  logic        g_err;

  fir_sample_feeder #(.WIDTH(16), .DEPTH(8), .MIN_GAP(0), .TIMEOUT(64)) dut (
    .clock(clock), .rst(rst),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .fir_in(fir_in), .fir_input_ready(fir_input_ready),
    .fir_output_ready(fir_output_ready),
    .fifo_level(fifo_level), .busy(busy),
    .clear_err(clear_err), .timeout_err(timeout_err)
  );

  fir_sample_feeder #(.WIDTH(16), .DEPTH(8), .MIN_GAP(3), .TIMEOUT(64)) dut_gap (
    .clock(clock), .rst(rst),
    .in_data(g_in_data), .in_valid(g_in_valid), .in_ready(g_in_ready),
    .fir_in(g_fir_in), .fir_input_ready(g_strobe),
    .fir_output_ready(g_ack),
    .fifo_level(g_level), .busy(g_busy),
    .clear_err(g_clear_err), .timeout_err(g_err)
  );

  // ---------------------------------------------------------------------------
  // Behavioural FIR: records every strobe, convolves with COEF in Q15 and
  // pulses completion stub_lat falling edges after the strobe is seen.
  // ---------------------------------------------------------------------------
  localparam int COEF [16] = '{-2, 0, 10, 38, -86, 200, 1024, 4096,
                               4096, 1024, 200, -86, 38, 10, 0, -2};

  logic              stub_en;
  int                stub_lat;
  int                stub_cnt;
  logic              stub_ack;
  logic              spur;
  logic signed [15:0] xs [16];

  logic [15:0] issued[$];
  int          issued_edge[$];
  int          ack_edges[$];
  int          ys[$];

  assign fir_output_ready = stub_ack | spur;

  function automatic int fir_model();
    int acc = 0;
    for (int i = 0; i < 16; i++) acc += COEF[i] * int'(xs[i]);
    return acc >>> 15;
  endfunction

  always @(negedge clock) begin
    stub_ack <= 1'b0;
    if (rst) begin
      stub_cnt <= 0;
      for (int i = 0; i < 16; i++) xs[i] <= '0;
    end else begin
      if (fir_input_ready) begin
        issued.push_back(fir_in);
        issued_edge.push_back(cyc);
      end
      if (stub_en && fir_input_ready) begin
        xs[0] <= fir_in;
        for (int i = 1; i < 16; i++) xs[i] <= xs[i-1];
        stub_cnt <= stub_lat;
      end else if (stub_cnt == 1) begin
        stub_ack <= 1'b1;
        stub_cnt <= 0;
        ack_edges.push_back(cyc + 1);
        ys.push_back(fir_model());
      end else if (stub_cnt > 1) begin
        stub_cnt <= stub_cnt - 1;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Checking helpers
  // ---------------------------------------------------------------------------
  int pass_cnt = 0;
  int chk_cnt  = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    chk_cnt++;
    if (got === exp) pass_cnt++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  task automatic step();
    @(negedge clock);
    #1;
  endtask

  logic [15:0] pq[$];
  int          acc_edge[$];
  int          saw_full;
  int          full_ready_bad;

  // Offers pq in order, holding each value until it is accepted.
  task automatic push_seq();
    int i = 0;
    int budget = 2000;
    in_valid = 1'b1;
    in_data  = pq[0];
    while (i < pq.size() && budget > 0) begin
      if (fifo_level == 4'd8) begin
        saw_full = 1;
        if (in_ready !== 1'b0) full_ready_bad++;
      end
      if (in_ready) begin
        acc_edge.push_back(cyc + 1);
        i++;
      end
      step();
      if (i < pq.size()) in_data = pq[i];
      budget--;
    end
    in_valid = 1'b0;
    check("push_done", i, pq.size());
  endtask

  task automatic wait_issued(input int n, input string tag);
    int budget = 800;
    while (issued.size() < n && budget > 0) begin
      step();
      budget--;
    end
    check(tag, issued.size() >= n, 1);
  endtask

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  initial begin
    int base, abase, ybase, k, s, n, fall_edge, err_edge, ack_e;
    int hold_bad, ir_bad;
    logic was_busy;

    stub_en = 1'b1; stub_lat = 18; spur = 1'b0; clear_err = 1'b0;
    in_valid = 1'b0; in_data = '0;
    g_in_valid = 1'b0; g_in_data = '0; g_ack = 1'b0; g_clear_err = 1'b0;

    // Reset values
    repeat (3) step();
    check("rst_fir_in", fir_in, 16'h0000);
    check("rst_strobe", fir_input_ready, 1'b0);
    check("rst_level", fifo_level, 4'd0);
    check("rst_in_ready", in_ready, 1'b1);
    check("rst_busy", busy, 1'b0);
    check("rst_err", timeout_err, 1'b0);
    rst = 1'b0;
    step();

    // Single sample, 18-cycle FIR
    base = issued.size();
    abase = ack_edges.size();
    in_valid = 1'b1; in_data = 16'h1234;
    k = cyc + 1;
    step();
    in_valid = 1'b0;
    hold_bad = 0; ir_bad = 0; fall_edge = -1; was_busy = 1'b0;
    repeat (40) begin
      step();
      if (busy && fir_in !== 16'h1234) hold_bad++;
      if (!in_ready) ir_bad++;
      if (was_busy && !busy && fall_edge < 0) fall_edge = cyc;
      was_busy = busy;
    end
    check("single_count", issued.size(), base + 1);
    check("single_value", issued[base], 16'h1234);
    check("single_latency", issued_edge[base], k + 1);
    check("single_hold", hold_bad, 0);
    check("single_in_ready", ir_bad, 0);
    check("single_busy_fall", fall_edge, ack_edges[abase]);
    check("single_idle", busy, 1'b0);

    // Fill and backpressure: a leading sample occupies the FIR, then -1..-9
    base = issued.size();
    abase = ack_edges.size();
    pq.delete();
    pq.push_back(16'h0100);
    for (int i = 1; i <= 9; i++) pq.push_back(16'(-i));
    acc_edge.delete(); saw_full = 0; full_ready_bad = 0;
    push_seq();
    wait_issued(base + 10, "fill_drain");
    repeat (30) step();
    check("fill_count", issued.size(), base + 10);
    for (int i = 0; i < 10; i++) check($sformatf("fill_order%0d", i), issued[base+i], pq[i]);
    check("fill_saw_full", saw_full, 1);
    check("fill_full_blocks", full_ready_bad, 0);
    check("fill_9th_after_pop", acc_edge[9], issued_edge[base+1] + 1);
    check("b2b_next_strobe", issued_edge[base+1], ack_edges[abase] + 1);

    // Watchdog timeout with a silent FIR
    stub_en = 1'b0;
    base = issued.size();
    pq.delete();
    pq.push_back(16'h0AAA);
    pq.push_back(16'h0BBB);
    push_seq();
    n = 0;
    while (!timeout_err && n < 200) begin
      step();
      n++;
    end
    err_edge = cyc;
    s = issued_edge[base];
    check("to_edge", err_edge, s + 65);
    step();
    check("to_next_strobe", fir_input_ready, 1'b1);
    check("to_next_value", fir_in, 16'h0BBB);
    check("to_sticky", timeout_err, 1'b1);
    clear_err = 1'b1;
    step();
    clear_err = 1'b0;
    check("to_cleared", timeout_err, 1'b0);

    // Reset during BUSY with three samples queued
    rst = 1'b1; step(); rst = 1'b0; step();
    stub_en = 1'b1;
    pq.delete();
    for (int i = 1; i <= 4; i++) pq.push_back(16'(i));
    push_seq();
    step();
    check("mid_pre_level", fifo_level, 4'd3);
    check("mid_pre_busy", busy, 1'b1);
    #2 rst = 1'b1;
    #1;
    check("mid_strobe", fir_input_ready, 1'b0);
    check("mid_level", fifo_level, 4'd0);
    check("mid_busy", busy, 1'b0);
    check("mid_fir_in", fir_in, 16'h0000);
    check("mid_in_ready", in_ready, 1'b1);
    step();
    rst = 1'b0;
    step();
    base = issued.size();
    in_valid = 1'b1; in_data = 16'h7FFF;
    k = cyc + 1;
    step();
    in_valid = 1'b0;
    repeat (3) step();
    check("post_rst_count", issued.size(), base + 1);
    check("post_rst_value", issued[base], 16'h7FFF);
    check("post_rst_latency", issued_edge[base], k + 1);
    n = 0;
    while (busy && n < 100) begin
      step();
      n++;
    end
    check("post_rst_done", busy, 1'b0);

    // Spurious completion while IDLE
    base = issued.size();
    spur = 1'b1;
    step();
    spur = 1'b0;
    repeat (3) step();
    check("spur_idle_busy", busy, 1'b0);
    check("spur_idle_nostrobe", issued.size(), base);

    // Gap timing on the MIN_GAP=3 instance, with a spurious pulse in GAP
    g_in_valid = 1'b1; g_in_data = 16'h0111;
    k = cyc + 1;
    step();
    g_in_data = 16'h0222;
    step();
    g_in_valid = 1'b0;
    n = 0;
    while (!g_strobe && n < 20) begin
      step();
      n++;
    end
    s = cyc;
    check("gap_first_latency", s, k + 1);
    repeat (4) step();
    g_ack = 1'b1;
    ack_e = cyc + 1;
    step();
    g_ack = 1'b0;
    check("gap_busy", g_busy, 1'b1);
    g_ack = 1'b1;
    step();
    g_ack = 1'b0;
    n = 0;
    while (!g_strobe && n < 20) begin
      step();
      n++;
    end
    check("gap_second_edge", cyc, ack_e + 4);
    check("gap_second_value", g_fir_in, 16'h0222);

    // Impulse through the behavioural FIR
    rst = 1'b1; step(); rst = 1'b0; step();
    ybase = ys.size();
    base = issued.size();
    pq.delete();
    pq.push_back(16'h4000);
    for (int i = 1; i < 16; i++) pq.push_back(16'h0000);
    push_seq();
    n = 0;
    while (ys.size() < ybase + 16 && n < 800) begin
      step();
      n++;
    end
    check("fir_strobes", issued.size(), base + 16);
    check("fir_outputs", ys.size(), ybase + 16);
    for (int i = 0; i < 16; i++) check($sformatf("fir_y%0d", i), ys[ybase+i], COEF[i] / 2);

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule

// File: doc/fir_sample_feeder.md
Name: fir_sample_feeder

Overview:
- Upstream stage of the 16-tap FIR filter. Accepts 16-bit signed samples from a valid/ready source and buffers them in a small FIFO.
- Issues samples to the FIR one at a time: a one-cycle input_ready strobe, with the sample held stable until the FIR signals output_ready.
- Hides the FIR's ~19-cycle per-sample occupancy from the producer.
- Adds an optional inter-sample gap and a busy watchdog.

Parameters:
- WIDTH, 16, sample width in bits.
- DEPTH, 8, FIFO depth in entries; power of 2, at least 2.
- MIN_GAP, 0, idle cycles inserted after fir_output_ready before the next strobe.
- TIMEOUT, 64, maximum cycles spent waiting for fir_output_ready before the error path.

Ports:
- clock  input  1  rising-edge clock
- rst  input  1  asynchronous reset, active-high
- in_data  input  WIDTH  signed sample from producer
- in_valid  input  1  producer has a sample
- in_ready  output  1  feeder can accept; equals FIFO not full (combinational from registered count)
- fir_in  output  WIDTH  signed sample to FIR `in`; registered
- fir_input_ready  output  1  one-cycle strobe to FIR `input_ready`; registered
- fir_output_ready  input  1  FIR completion pulse
- fifo_level  output  $clog2(DEPTH)+1  current FIFO occupancy
- busy  output  1  high whenever state is not IDLE
- clear_err  input  1  synchronous clear of timeout_err
- timeout_err  output  1  sticky watchdog flag

Behaviour:
- Reset (async, rst=1):
  - state=IDLE; FIFO pointers and count cleared.
  - fir_in=0, fir_input_ready=0, fifo_level=0, in_ready=1, busy=0, timeout_err=0, gap and watchdog counters=0.
  - FIFO contents are not reset.
  - A reset during BUSY abandons the sample in flight. The FIR shares rst, so it resets too.
- FIFO push and pop:
  - Push on an edge where in_valid && in_ready.
  - Pop only from IDLE, when count != 0.
  - When full, in_ready=0. No push occurs even if a pop happens on the same edge.
  - A simultaneous push and pop with 0 < count < DEPTH leaves count unchanged.
  - Pointers wrap modulo DEPTH.
  - Samples are issued strictly in acceptance order; no sample is dropped or duplicated.
- States and transitions:
  - IDLE: if count != 0, pop the head into fir_in, set fir_input_ready<=1, go to ISSUE. Otherwise stay.
  - ISSUE (exactly 1 cycle, fir_input_ready=1): clear fir_input_ready, clear the watchdog, go to BUSY.
  - BUSY:
    - fir_in is held stable.
    - If fir_output_ready=1: go to GAP when MIN_GAP>0 (load the gap counter with MIN_GAP), else go to IDLE.
    - Else if the watchdog reaches TIMEOUT-1: set timeout_err, go to IDLE.
    - Else increment the watchdog.
  - GAP: decrement the gap counter; go to IDLE when it reaches 1.
- fir_output_ready seen in IDLE, ISSUE or GAP is ignored (spurious). It is not counted.
- fir_in hold rule:
  - fir_in changes only on the IDLE->ISSUE edge.
  - It stays stable through ISSUE and BUSY. This covers the FIR's waiting->loading sampling cycle.
- Latency:
  - Sample accepted on edge k into an empty FIFO while in IDLE.
  - fir_in updates and fir_input_ready rises on edge k+1; fir_input_ready falls on edge k+2.
- Back-to-back issue: the next strobe rises at the earliest MIN_GAP+1 edges after the edge where fir_output_ready is sampled in BUSY.
- timeout_err:
  - Set by the watchdog; cleared only by clear_err or rst.
  - If clear_err and a timeout occur on the same edge, set wins.
- busy and fifo_level are registered or derived from registered state only; no input-to-output combinational path except through in_ready, which depends on count only.
- No arithmetic on sample data: samples pass through bit-exact, sign preserved.

Test Plan:
- Single sample: after reset, push 16'sh1234 with FIR stub completing 18 cycles after the strobe.
  - Expect fir_input_ready high for exactly 1 cycle on edge k+1, fir_in=0x1234 held until completion.
  - Expect busy to return to 0 one edge after fir_output_ready; in_ready stays 1.
- Fill and backpressure: push 9 samples (-1, -2, ... -9) back-to-back while the FIR is busy, DEPTH=8.
  - Expect in_ready=0 once fifo_level=8, with the 9th held by the producer and accepted after the first pop.
  - Expect all 9 values to appear on fir_in in order, each strobed once.
- Gap timing: MIN_GAP=3, two queued samples, stub completes after 5 cycles.
  - Expect the second strobe exactly 4 edges after the first fir_output_ready sample edge.
- Timeout: stub never responds, TIMEOUT=64.
  - Expect timeout_err=1 64 cycles after entering BUSY, return to IDLE, and the next queued sample issued.
  - Pulse clear_err; expect timeout_err=0.
- Reset mid-operation: assert rst during BUSY with fifo_level=3.
  - Expect immediate fir_input_ready=0, fifo_level=0, busy=0, fir_in=0.
  - After release, push 16'sh7FFF; expect it to issue normally.
- Spurious completion: pulse fir_output_ready while IDLE and during GAP.
  - Expect no state change and no strobe.
- Integration with the real FIR:
  - Impulse 16'sh4000 followed by 15 zeros.
  - Expect the FIR outputs to equal coefficient/2, in coefficient order, with no lost strobes.
